wb_mp_ram: RTL and testbench

- Multi-port Wishbone RAM. NUM_PORTS independent slave ports share one single-clock memory array through a round-robin arbiter.
- Completes at most one access per clock across all ports, with per-byte write enables, an error response for out-of-range addresses and a selectable read latency.
- Sits on the system bus as shared memory for the CPU data bus, DMA engines and peripheral masters.

---
 rtl/wb_mp_ram_if.sv | 28 ++
 rtl/wb_mp_ram.sv | 144 ++++++++++++++
 tb/tb_wb_mp_ram.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mp_ram_if.sv
// rtl/wb_mp_ram_if.sv - Bundled multi-port Wishbone signals for wb_mp_ram
interface wb_mp_ram_if #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH   = 18
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   wb_adr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   wb_dat_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   wb_dat_o;
  logic [NUM_PORTS-1:0]              wb_we_i;
  logic [NUM_PORTS*SELECT_WIDTH-1:0] wb_sel_i;
  logic [NUM_PORTS-1:0]              wb_stb_i;
  logic [NUM_PORTS-1:0]              wb_cyc_i;
  logic [NUM_PORTS-1:0]              wb_ack_o;
  logic [NUM_PORTS-1:0]              wb_err_o;
  logic [NUM_PORTS-1:0]              wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );
endinterface

// File: rtl/wb_mp_ram.sv
// rtl/wb_mp_ram.sv - Multi-port Wishbone RAM, round-robin arbitrated, one access per clock
`ifndef MEMORY_UNIT_SIZE
`define MEMORY_UNIT_SIZE 8192
`endif

module wb_mp_ram #(
  parameter int NUM_PORTS            = 4,
  parameter int DATA_WIDTH           = 32,
  parameter int SELECT_WIDTH         = DATA_WIDTH / 8,
  parameter int NUM_OF_SYS_MEM_UNITS = 31,
  parameter int ADDR_WIDTH           = $clog2(NUM_OF_SYS_MEM_UNITS * `MEMORY_UNIT_SIZE),
  parameter int READ_LATENCY         = 1,
  parameter int LOAD_IMAGE           = 0,
  parameter     IMAGE_FILE           = "@IMAGE@"
) (
  input logic        clk,
  input logic        rst,
  wb_mp_ram_if.slave bus
);
  localparam int MEM_BYTES = NUM_OF_SYS_MEM_UNITS * `MEMORY_UNIT_SIZE / 8;
  localparam int SHIFT     = $clog2(SELECT_WIDTH);
  localparam int WORDS     = MEM_BYTES / SELECT_WIDTH;
  localparam int WIDX      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [NUM_PORTS-1:0]            req, grant, pend_q, pend_d;
  logic [PW-1:0]                   ptr_q, ptr_d, gidx;
  logic                            gvalid;
  logic [ADDR_WIDTH-1:0]           g_adr;
  logic [DATA_WIDTH-1:0]           g_dat;
  logic [SELECT_WIDTH-1:0]         g_sel;
  logic                            g_we, g_in_range;
  logic [WIDX-1:0]                 g_word;
  logic [NUM_PORTS-1:0]            ack1_q, ack1_d, err1_q, err1_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dat1_q, dat1_d;
  logic [NUM_PORTS-1:0]            ack_out, err_out;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dat_out;

  assign req = bus.wb_cyc_i & bus.wb_stb_i & ~pend_q;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    int idx;
    idx    = 0;
    gvalid = 1'b0;
    gidx   = ptr_q;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_PORTS;
      if (!gvalid && req[idx]) begin
        gvalid = 1'b1;
        gidx   = PW'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gvalid) grant[gidx] = 1'b1;
  end

  assign g_adr      = bus.wb_adr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_dat      = bus.wb_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign g_sel      = bus.wb_sel_i[gidx*SELECT_WIDTH +: SELECT_WIDTH];
  assign g_we       = bus.wb_we_i[gidx];
  assign g_in_range = {1'b0, g_adr} < MEM_LIMIT;
  assign g_word     = g_adr[SHIFT +: WIDX];

  always_ff @(posedge clk) begin
    if (!rst && gvalid && g_we && g_in_range) begin
      for (int i = 0; i < SELECT_WIDTH; i++) begin
        if (g_sel[i]) mem[g_word][i*8 +: 8] <= g_dat[i*8 +: 8];
      end
    end
  end

  // Pending holds off re-acceptance until the edge after the termination pulse.
  always_comb begin
    ptr_d  = gvalid ? gidx : ptr_q;
    pend_d = (pend_q & ~(ack_out | err_out)) | grant;
    ack1_d = '0;
    err1_d = '0;
    dat1_d = dat1_q;
    if (gvalid) begin
      ack1_d[gidx] = g_in_range;
      err1_d[gidx] = ~g_in_range;
      dat1_d[gidx*DATA_WIDTH +: DATA_WIDTH] = g_in_range ? mem[g_word] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= PW'(NUM_PORTS - 1);
      pend_q <= '0;
      ack1_q <= '0;
      err1_q <= '0;
      dat1_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
      ack1_q <= ack1_d;
      err1_q <= err1_d;
      dat1_q <= dat1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [NUM_PORTS-1:0]            ack2_q, ack2_d, err2_q, err2_d;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dat2_q, dat2_d;

    always_comb begin
      ack2_d = ack1_q;
      err2_d = err1_q;
      dat2_d = dat1_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ack2_q <= '0;
        err2_q <= '0;
        dat2_q <= '0;
      end else begin
        ack2_q <= ack2_d;
        err2_q <= err2_d;
        dat2_q <= dat2_d;
      end
    end

    assign ack_out = ack2_q;
    assign err_out = err2_q;
    assign dat_out = dat2_q;
  end else begin : g_lat1
    assign ack_out = ack1_q;
    assign err_out = err1_q;
    assign dat_out = dat1_q;
  end

  assign bus.wb_ack_o   = ack_out;
  assign bus.wb_err_o   = err_out;
  assign bus.wb_dat_o   = dat_out;
  assign bus.wb_stall_o = req & ~grant;
endmodule

// File: tb/tb_wb_mp_ram.sv
// tb/tb_wb_mp_ram.sv - Scoreboard bench for wb_mp_ram at read latency 1 and 2
`ifndef MEMORY_UNIT_SIZE
`define MEMORY_UNIT_SIZE 8192
`endif

module tb_wb_mp_ram;
  localparam int NP        = 4;
  localparam int DW        = 32;
  localparam int SW        = 4;
  localparam int MEM_BITS  = 31 * `MEMORY_UNIT_SIZE;
  localparam int AW        = $clog2(MEM_BITS);
  localparam int MEM_BYTES = MEM_BITS / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_mp_ram_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .ADDR_WIDTH(AW)) b1 ();
  wb_mp_ram_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .ADDR_WIDTH(AW)) b2 ();

  wb_mp_ram #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .ADDR_WIDTH(AW),
              .READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  wb_mp_ram #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .ADDR_WIDTH(AW),
              .READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    int              d;
    int              p;
    bit              err;
    bit              chk;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;
  int   term_cnt [2][NP];
  int   term_cyc [2][NP];

  // One clock; terminations are popped against the scoreboard and the master drops stb/cyc.
  task automatic tick();
    logic [NP-1:0]    ack, err;
    logic [NP*DW-1:0] dat;
    int               k;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      ack = (d == 0) ? b1.wb_ack_o : b2.wb_ack_o;
      err = (d == 0) ? b1.wb_err_o : b2.wb_err_o;
      dat = (d == 0) ? b1.wb_dat_o : b2.wb_dat_o;
      for (int p = 0; p < NP; p++) begin
        if (ack[p] || err[p]) begin
          term_cnt[d][p]++;
          term_cyc[d][p] = cyc_n;
          k = -1;
          foreach (sb[i]) if (k < 0 && sb[i].d == d && sb[i].p == p) k = i;
          checks++;
          if (k < 0) begin
            errors++;
            $display("FAIL sb_unexpected dut%0d port%0d: got ack=%b err=%b, required no termination",
                     d, p, ack[p], err[p]);
          end else begin
            if ({ack[p], err[p]} !== {~sb[k].err, sb[k].err}) begin
              errors++;
              $display("FAIL sb_term dut%0d port%0d: got ack=%b err=%b, required ack=%b err=%b",
                       d, p, ack[p], err[p], ~sb[k].err, sb[k].err);
            end
            if (sb[k].chk) begin
              checks++;
              if (dat[p*DW +: DW] !== sb[k].data) begin
                errors++;
                $display("FAIL sb_data dut%0d port%0d: got %h, required %h",
                         d, p, dat[p*DW +: DW], sb[k].data);
              end
            end
            sb.delete(k);
          end
          if (d == 0) begin
            b1.wb_stb_i[p] = 1'b0;
            b1.wb_cyc_i[p] = 1'b0;
          end else begin
            b2.wb_stb_i[p] = 1'b0;
            b2.wb_cyc_i[p] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic issue(input int d, input int p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] sel, input bit push,
                       input bit exp_err, input bit chk, input logic [DW-1:0] exp_dat);
    exp_t e;
    if (d == 0) begin
      b1.wb_adr_i[p*AW +: AW] = a;
      b1.wb_dat_i[p*DW +: DW] = wd;
      b1.wb_sel_i[p*SW +: SW] = sel;
      b1.wb_we_i[p]           = we;
      b1.wb_stb_i[p]          = 1'b1;
      b1.wb_cyc_i[p]          = 1'b1;
    end else begin
      b2.wb_adr_i[p*AW +: AW] = a;
      b2.wb_dat_i[p*DW +: DW] = wd;
      b2.wb_sel_i[p*SW +: SW] = sel;
      b2.wb_we_i[p]           = we;
      b2.wb_stb_i[p]          = 1'b1;
      b2.wb_cyc_i[p]          = 1'b1;
    end
    if (push) begin
      e.d = d; e.p = p; e.err = exp_err; e.chk = chk; e.data = exp_dat;
      sb.push_back(e);
    end
  endtask

  // Runs until all masters are idle, plus one clock so pending flags clear.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((b1.wb_cyc_i != '0 || b2.wb_cyc_i != '0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: got %0d outstanding after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
      b1.wb_stb_i = '0; b1.wb_cyc_i = '0; b2.wb_stb_i = '0; b2.wb_cyc_i = '0;
    end
    tick();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++) begin
        term_cnt[d][p] = 0;
        term_cyc[d][p] = 0;
      end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    b1.wb_adr_i = '0; b1.wb_dat_i = '0; b1.wb_sel_i = '0; b1.wb_we_i = '0;
    b1.wb_stb_i = '0; b1.wb_cyc_i = '0;
    b2.wb_adr_i = '0; b2.wb_dat_i = '0; b2.wb_sel_i = '0; b2.wb_we_i = '0;
    b2.wb_stb_i = '0; b2.wb_cyc_i = '0;
    clear_counts();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({b1.wb_ack_o, b1.wb_err_o, b2.wb_ack_o, b2.wb_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_ack_err: got %h, required 0",
               {b1.wb_ack_o, b1.wb_err_o, b2.wb_ack_o, b2.wb_err_o});
    end
    checks++;
    if (b1.wb_dat_o !== '0 || b2.wb_dat_o !== '0) begin
      errors++;
      $display("FAIL reset_dat: got %h / %h, required 0", b1.wb_dat_o, b2.wb_dat_o);
    end
    checks++;
    if (b1.wb_stall_o !== '0 || b2.wb_stall_o !== '0) begin
      errors++;
      $display("FAIL reset_stall: got %b / %b, required 0", b1.wb_stall_o, b2.wb_stall_o);
    end
  endtask

  task automatic test_single_port();
    int            c;
    logic [NP-1:0] st;
    for (int d = 0; d < 2; d++) begin
      for (int rd = 0; rd < 2; rd++) begin
        c = cyc_n;
        issue(d, 0, rd == 0, AW'(32'h10), 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, rd == 1, 32'hDEADBEEF);
        #1;
        st = (d == 0) ? b1.wb_stall_o : b2.wb_stall_o;
        checks++;
        if (st !== '0) begin
          errors++;
          $display("FAIL single_stall dut%0d: got %b, required 0", d, st);
        end
        wait_idle(10);
        checks++;
        if (term_cyc[d][0] - c != d + 1) begin
          errors++;
          $display("FAIL single_latency dut%0d: got %0d, required %0d", d, term_cyc[d][0] - c, d + 1);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    issue(0, 0, 1'b1, AW'(32'h20), 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, '0);
    wait_idle(10);
    issue(0, 0, 1'b1, AW'(32'h20), 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 1'b0, '0);
    wait_idle(10);
    issue(0, 0, 1'b0, AW'(32'h20), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h11BB33DD);
    wait_idle(10);
    issue(0, 0, 1'b1, AW'(32'h20), 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 1'b0, '0);
    wait_idle(10);
    issue(0, 0, 1'b0, AW'(32'h20), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h11BB33DD);
    wait_idle(10);
  endtask

  task automatic test_contention();
    int            c;
    logic [NP-1:0] exp_st;
    pulse_reset();
    clear_counts();
    c = cyc_n;
    for (int p = 0; p < NP; p++)
      issue(0, p, 1'b1, AW'(32'h100 + 4 * p), 32'hA0 + p, 4'hF, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < NP; k++) begin
      #1;
      exp_st = NP'(4'b1110 << k);
      checks++;
      if (b1.wb_stall_o !== exp_st) begin
        errors++;
        $display("FAIL contention_stall cycle%0d: got %b, required %b", k, b1.wb_stall_o, exp_st);
      end
      tick();
    end
    wait_idle(10);
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (term_cnt[0][p] != 1 || term_cyc[0][p] != c + 1 + p) begin
        errors++;
        $display("FAIL contention_ack port%0d: got count=%0d cycle=%0d, required count=1 cycle=%0d",
                 p, term_cnt[0][p], term_cyc[0][p] - c, 1 + p);
      end
    end
    for (int p = 0; p < NP; p++)
      issue(0, p, 1'b0, AW'(32'h100 + 4 * p), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'hA0 + p);
    wait_idle(20);
  endtask

  task automatic test_cross_port();
    issue(0, 2, 1'b1, AW'(32'h40), 32'h0000CAFE, 4'hF, 1'b1, 1'b0, 1'b0, '0);
    tick();
    issue(0, 1, 1'b0, AW'(32'h40), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h0000CAFE);
    wait_idle(10);
  endtask

  task automatic test_range();
    logic [AW-1:0] top;
    top = '1;
    top = top - AW'(3);
    issue(0, 0, 1'b1, AW'(MEM_BYTES - 4), 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0, 1'b0, '0);
    wait_idle(10);
    issue(0, 0, 1'b0, AW'(MEM_BYTES - 4), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    wait_idle(10);
    issue(0, 3, 1'b0, AW'(MEM_BYTES), '0, 4'hF, 1'b1, 1'b1, 1'b1, '0);
    wait_idle(10);
    issue(0, 3, 1'b1, AW'(MEM_BYTES), 32'h13579BDF, 4'hF, 1'b1, 1'b1, 1'b1, '0);
    wait_idle(10);
    issue(0, 2, 1'b1, top, 32'h2468ACE0, 4'hF, 1'b1, 1'b1, 1'b1, '0);
    wait_idle(10);
    issue(0, 0, 1'b0, AW'(MEM_BYTES - 4), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    wait_idle(10);
  endtask

  task automatic test_reset_pending();
    clear_counts();
    issue(1, 3, 1'b0, AW'(32'h10), '0, 4'hF, 1'b0, 1'b0, 1'b0, '0);
    tick();
    issue(0, 3, 1'b1, AW'(32'h10), 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b1.wb_stb_i[3] = 1'b0; b1.wb_cyc_i[3] = 1'b0;
    b2.wb_stb_i[3] = 1'b0; b2.wb_cyc_i[3] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (term_cnt[0][3] != 0 || term_cnt[1][3] != 0) begin
      errors++;
      $display("FAIL reset_abandon port3: got %0d / %0d terminations, required 0 / 0",
               term_cnt[0][3], term_cnt[1][3]);
    end
    issue(0, 0, 1'b0, AW'(32'h10), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    issue(1, 0, 1'b0, AW'(32'h10), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_idle(10);
    // Leave the pointer on port 1, then check reset puts port 0 first again.
    issue(0, 1, 1'b0, AW'(32'h10), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_idle(10);
    pulse_reset();
    for (int p = 0; p < NP; p++)
      issue(0, p, 1'b0, AW'(32'h10), '0, 4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    #1;
    checks++;
    if (b1.wb_stall_o !== 4'b1110) begin
      errors++;
      $display("FAIL reset_pointer: got stall %b, required 1110", b1.wb_stall_o);
    end
    wait_idle(20);
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_byte_lanes();
    test_contention();
    test_cross_port();
    test_range();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
